// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: groups the fetch controller's two handshakes.
//   Memory side : mem_next_instr (request), mem_instr / mem_instr_valid (1-cycle response)
//   Decode side : fetch_instr / fetch_pc / fetch_valid (head of buffer), fetch_ready (accept)
// Modports:
//   master - the fetch controller (drives requests and the decode-side head)
//   slave  - memory plus decode stage (or a bench standing in for both)
interface fetch_ctrl_if;
  logic        mem_next_instr;
  logic [31:0] mem_instr;
  logic        mem_instr_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        fetch_ready;

  modport master (
    output mem_next_instr,
    input  mem_instr,
    input  mem_instr_valid,
    output fetch_instr,
    output fetch_pc,
    output fetch_valid,
    input  fetch_ready
  );

  modport slave (
    input  mem_next_instr,
    output mem_instr,
    output mem_instr_valid,
    input  fetch_instr,
    input  fetch_pc,
    input  fetch_valid,
    output fetch_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequences the instruction memory for one pass of NUM_INSTR words per start,
// buffers returned words with their PC in a DEPTH-entry FIFO and hands them to decode.
// Ports:
//   clk, reset_n  - rising-edge clock, asynchronous active-low reset
//   start         - begin a pass (honoured in IDLE or DONE only)
//   flush         - discard buffered words and any outstanding response
//   bus           - fetch_ctrl_if.master: memory request/response and decode valid/ready
//   busy          - pass in progress (FETCH or DRAIN)
//   done          - pass complete (DONE)
module fetch_ctrl #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NUM_INSTR = 64,
  parameter logic [31:0] PC_RESET  = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         flush,
  fetch_ctrl_if.master bus,
  output logic         busy,
  output logic         done
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned IssW = $clog2(NUM_INSTR) + 1;

  localparam logic [CntW:0]   DepthVal    = DEPTH[CntW:0];
  localparam logic [IssW-1:0] NumInstrVal = NUM_INSTR[IssW-1:0];

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [IssW-1:0]   issue_cnt_q, issue_cnt_d;
  logic [31:0]       issue_pc_q, issue_pc_d;
  logic [31:0]       pend_pc_q, pend_pc_d;
  logic              inflight_q, inflight_d;
  logic              drop_q, drop_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic [31:0]       instr_mem [DEPTH];
  logic [31:0]       pc_mem    [DEPTH];

  logic              issue;
  logic              push;
  logic              pop;
  logic              enter_fetch;
  logic              head_valid;
  logic [CntW:0]     occupancy;

  // Credit covers both stored words and the one response that may still be coming back,
  // so the FIFO can never overflow. A pop this cycle does not free a credit until next cycle.
  assign occupancy  = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
  assign issue      = (state_q == StFetch) && (issue_cnt_q < NumInstrVal) &&
                      (occupancy < DepthVal) && !flush;
  assign head_valid = (count_q != '0);
  assign push       = bus.mem_instr_valid && !drop_q && !flush;
  assign pop        = head_valid && bus.fetch_ready && !flush;

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pass sequencing
  always_comb begin
    state_d     = state_q;
    enter_fetch = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StFetch;
          enter_fetch = 1'b1;
        end
      end
      StFetch: begin
        if (issue_cnt_q == NumInstrVal) state_d = StDrain;
      end
      StDrain: begin
        // Looking at count_d lets done rise right after the final pop.
        if ((count_d == '0) && !inflight_q && !drop_q) state_d = StDone;
      end
      StDone: begin
        if (start) begin
          state_d     = StFetch;
          enter_fetch = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Issue bookkeeping
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    issue_pc_d  = issue_pc_q;
    pend_pc_d   = pend_pc_q;
    inflight_d  = issue;
    drop_d      = drop_q;
    if (enter_fetch) begin
      issue_cnt_d = '0;
      issue_pc_d  = PC_RESET;
    end else if (issue) begin
      issue_cnt_d = issue_cnt_q + IssW'(1);
      issue_pc_d  = issue_pc_q + 32'd4;
    end
    if (issue) pend_pc_d = issue_pc_q;
    // A response already present this cycle is blocked by flush directly; only one that has
    // not yet arrived needs to be remembered and discarded later.
    if (flush && inflight_q && !bus.mem_instr_valid) begin
      drop_d = 1'b1;
    end else if (bus.mem_instr_valid) begin
      drop_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      issue_cnt_q <= '0;
      issue_pc_q  <= '0;
      pend_pc_q   <= '0;
      inflight_q  <= 1'b0;
      drop_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      issue_pc_q  <= issue_pc_d;
      pend_pc_q   <= pend_pc_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= bus.mem_instr;
      pc_mem[wr_ptr_q]    <= pend_pc_q;
    end
  end

  assign bus.mem_next_instr = issue;
  assign bus.fetch_valid    = head_valid;
  assign bus.fetch_instr    = head_valid ? instr_mem[rd_ptr_q] : 32'h0;
  assign bus.fetch_pc       = head_valid ? pc_mem[rd_ptr_q]    : 32'h0;
  assign busy               = (state_q == StFetch) || (state_q == StDrain);
  assign done               = (state_q == StDone);

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic start   = 1'b0;
  logic flush   = 1'b0;
  logic ready   = 1'b0;
  logic busy;
  logic done;

  fetch_ctrl_if ifc ();

  fetch_ctrl #(
    .DEPTH     (4),
    .NUM_INSTR (64),
    .PC_RESET  (32'h0000_0000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .flush   (flush),
    .bus     (ifc),
    .busy    (busy),
    .done    (done)
  );

  assign ifc.fetch_ready = ready;

  always #5 clk = ~clk;

  // Instruction memory model: word i = 32'h1000_0000 + i, one-cycle latency, address wraps.
  logic [5:0] mem_addr;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr            <= 6'd0;
      ifc.mem_instr_valid <= 1'b0;
      ifc.mem_instr       <= 32'h0;
    end else begin
      ifc.mem_instr_valid <= ifc.mem_next_instr;
      if (ifc.mem_next_instr) begin
        ifc.mem_instr <= 32'h1000_0000 + {26'd0, mem_addr};
        mem_addr      <= mem_addr + 6'd1;
      end
    end
  end

  // Responses must only ever come back for an outstanding request.
  int stray_cnt = 0;
  always @(posedge clk) begin
    if (reset_n && ifc.mem_instr_valid && !dut.inflight_q) stray_cnt <= stray_cnt + 1;
  end

  int checks  = 0;
  int errors  = 0;
  int exp_idx = 0;
  int req_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard for every word accepted by decode.
  task automatic monitor();
    if (ifc.mem_next_instr) req_cnt++;
    if (ifc.fetch_valid && ready) begin
      check($sformatf("pop%0d_instr", exp_idx), ifc.fetch_instr, 32'h1000_0000 + 32'(exp_idx));
      check($sformatf("pop%0d_pc", exp_idx), ifc.fetch_pc, 32'(exp_idx) * 32'd4);
      exp_idx++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass();
    exp_idx = 0;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n = 0;
    while (!done && n < max_cycles) begin
      step();
      n++;
    end
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  typedef struct {
    logic        start;
    logic        ready;
    logic        mnx;
    logic        fv;
    logic        busy;
    logic        done;
    logic [31:0] instr;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int n;
    int stable_bad;

    // start, ready | mem_next_instr, fetch_valid, busy, done, fetch_instr, fetch_pc
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1000_0000, 32'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1000_0000, 32'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1000_0000, 32'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1000_0000, 32'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1000_0000, 32'd0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1000_0001, 32'd4};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1000_0002, 32'd8};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1000_0003, 32'd12};

    // Reset values
    #12;
    check("rst_mnx",   {31'd0, ifc.mem_next_instr}, 32'd0);
    check("rst_fv",    {31'd0, ifc.fetch_valid},    32'd0);
    check("rst_instr", ifc.fetch_instr,             32'd0);
    check("rst_pc",    ifc.fetch_pc,                32'd0);
    check("rst_busy",  {31'd0, busy},               32'd0);
    check("rst_done",  {31'd0, done},               32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();

    // Cycle-accurate start-up under backpressure, then release
    exp_idx = 0;
    for (int i = 0; i < 11; i++) begin
      start = tbl[i].start;
      ready = tbl[i].ready;
      @(negedge clk);
      check($sformatf("row%0d_mnx", i),   {31'd0, ifc.mem_next_instr}, {31'd0, tbl[i].mnx});
      check($sformatf("row%0d_fv", i),    {31'd0, ifc.fetch_valid},    {31'd0, tbl[i].fv});
      check($sformatf("row%0d_busy", i),  {31'd0, busy},               {31'd0, tbl[i].busy});
      check($sformatf("row%0d_done", i),  {31'd0, done},               {31'd0, tbl[i].done});
      check($sformatf("row%0d_instr", i), ifc.fetch_instr,             tbl[i].instr);
      check($sformatf("row%0d_pc", i),    ifc.fetch_pc,                tbl[i].pc);
      monitor();
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    ready = 1'b1;
    wait_done(120);
    check("tbl_pass_words", 32'(exp_idx), 32'd64);

    // Full-rate stream from DONE
    ready = 1'b1;
    start_pass();
    n = 0;
    while (exp_idx < 64 && n < 100) begin
      step();
      n++;
    end
    check("stream_words", 32'(exp_idx), 32'd64);
    check("stream_done_after_last_pop", {31'd0, done}, 32'd1);
    check("stream_latency_ok", {31'd0, (n + 1) <= 68}, 32'd1);

    // Backpressure for 20 cycles
    ready      = 1'b0;
    req_cnt    = 0;
    stable_bad = 0;
    start_pass();
    for (int i = 0; i < 20; i++) begin
      step();
      if (i >= 3 && (ifc.fetch_valid !== 1'b1 || ifc.fetch_instr !== 32'h1000_0000 ||
                     ifc.fetch_pc !== 32'd0)) stable_bad++;
    end
    check("bp_requests", 32'(req_cnt), 32'd4);
    check("bp_head_stable", 32'(stable_bad), 32'd0);
    ready = 1'b1;
    wait_done(120);
    check("bp_words", 32'(exp_idx), 32'd64);

    // Two passes with random ready
    for (int p = 0; p < 2; p++) begin
      start_pass();
      n = 0;
      while (!done && n < 600) begin
        ready = 1'($urandom_range(0, 1));
        step();
        n++;
      end
      check($sformatf("rand%0d_done", p), {31'd0, done}, 32'd1);
      check($sformatf("rand%0d_words", p), 32'(exp_idx), 32'd64);
    end

    // Push and pop together with count == DEPTH-1
    ready = 1'b0;
    start_pass();
    for (int i = 0; i < 5; i++) step();
    ready = 1'b1;
    step();
    ready = 1'b0;
    step();
    ready = 1'b1;
    @(negedge clk);
    check("c3_pre_count", {29'd0, dut.count_q}, 32'd3);
    check("c3_no_issue", {31'd0, ifc.mem_next_instr}, 32'd0);
    check("c3_push_arrives", {31'd0, ifc.mem_instr_valid}, 32'd1);
    monitor();
    @(posedge clk);
    #1;
    check("c3_post_count", {29'd0, dut.count_q}, 32'd3);
    wait_done(120);
    check("c3_words", 32'(exp_idx), 32'd64);

    // Flush with 3 buffered words and one response in flight
    ready = 1'b0;
    start_pass();
    for (int i = 0; i < 4; i++) step();
    check("fl_pre_count", {29'd0, dut.count_q}, 32'd3);
    check("fl_pre_inflight", {31'd0, dut.inflight_q}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_fv_low", {31'd0, ifc.fetch_valid}, 32'd0);
    check("fl_busy", {31'd0, busy}, 32'd1);
    exp_idx = 4;
    n = 0;
    while (!ifc.fetch_valid && n < 10) begin
      step();
      n++;
    end
    check("fl_next_instr", ifc.fetch_instr, 32'h1000_0004);
    check("fl_next_pc", ifc.fetch_pc, 32'd16);
    ready = 1'b1;
    wait_done(120);
    check("fl_words", 32'(exp_idx), 32'd64);

    // Asynchronous reset mid-pass
    ready = 1'b1;
    start_pass();
    n = 0;
    while (exp_idx < 30 && n < 100) begin
      step();
      n++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("mr_mnx",   {31'd0, ifc.mem_next_instr}, 32'd0);
    check("mr_fv",    {31'd0, ifc.fetch_valid},    32'd0);
    check("mr_instr", ifc.fetch_instr,             32'd0);
    check("mr_pc",    ifc.fetch_pc,                32'd0);
    check("mr_busy",  {31'd0, busy},               32'd0);
    check("mr_done",  {31'd0, done},               32'd0);
    step();
    reset_n = 1'b1;
    req_cnt = 0;
    for (int i = 0; i < 10; i++) step();
    check("mr_idle_no_req", 32'(req_cnt), 32'd0);
    check("mr_idle_busy", {31'd0, busy}, 32'd0);
    start_pass();
    wait_done(120);
    check("mr_restart_words", 32'(exp_idx), 32'd64);

    check("no_stray_response", 32'(stray_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
